// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: signal bundle for mem_arbiter.
//   Fetch side      : if_req, if_addr -> if_valid, if_rdata
//   Load/store side : d_req, d_we, d_size, d_addr, d_wdata -> d_valid, d_rdata, d_err
//   Memory side     : mem_address, mem_data_in, mem_w_enable -> mem_data_out
// Modports:
//   slave  - the arbiter
//   master - the core pipeline plus the memory instance
// Handshake: a requester raises *_req and holds its operands stable until the
// matching *_valid pulse, which lasts exactly one cycle. In the cycle after that
// pulse the requester drops *_req or presents a new request.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_valid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_w_enable;
  logic [31:0] mem_data_out;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_data_out,
    output if_valid, if_rdata, d_valid, d_rdata, d_err,
           mem_address, mem_data_in, mem_w_enable
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_data_out,
    input  if_valid, if_rdata, d_valid, d_rdata, d_err,
           mem_address, mem_data_in, mem_w_enable
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-wide memory port between instruction fetch and
// load/store. Sub-word accesses become aligned word accesses. Sub-word stores
// use read-modify-write. Range and alignment checks are applied at accept time.
// Ports:
//   clk       - clock
//   reset     - asynchronous, active-high reset
//   bus       - mem_arbiter_if.slave (fetch, load/store and memory signals)
//   state_dbg - current FSM state, for observation only
// Parameters: START_ADDRESS (first byte of the window), MEM_SIZE (window size in bytes).
// Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both
// units request together. Without it, load/store always wins a tie.
module mem_arbiter #(
  parameter logic [31:0] START_ADDRESS = 32'h01000000,
  parameter int unsigned MEM_SIZE      = 1048576
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus,
  output logic [2:0]   state_dbg
);
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;

  localparam logic [31:0] LAST_WA = START_ADDRESS + 32'(MEM_SIZE) - 32'd4;

  state_t      state, state_n;
  logic        own_d, own_d_n;          // 1: load/store owns the port, 0: fetch
  logic        own_we, own_we_n;
  logic [1:0]  own_size, own_size_n;
  logic [1:0]  own_off, own_off_n;
  logic [31:0] own_wdata, own_wdata_n;
  logic [31:0] word_q, word_n;          // word captured in READ, used by MERGE

  logic        if_valid_q, if_valid_n;
  logic [31:0] if_rdata_q, if_rdata_n;
  logic        d_valid_q, d_valid_n;
  logic [31:0] d_rdata_q, d_rdata_n;
  logic        d_err_q, d_err_n;
  logic [31:0] mem_addr_q, mem_addr_n;
  logic [31:0] mem_din_q, mem_din_n;
  logic        mem_we_q, mem_we_n;

  // Arbitration
  logic grant_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d, last_d_n;               // 1: last accept went to load/store
  always_comb grant_d = bus.d_req && (!bus.if_req || !last_d);
`else
  always_comb grant_d = bus.d_req;
`endif

  // Decode of the winning request. Fetch behaves as a word read.
  logic [31:0] req_addr, req_wa;
  logic [1:0]  req_off, req_size;
  logic        req_we, range_err, align_err;

  always_comb begin
    req_addr  = grant_d ? bus.d_addr : bus.if_addr;
    req_size  = grant_d ? bus.d_size : 2'b10;
    req_we    = grant_d && bus.d_we;
    req_wa    = {req_addr[31:2], 2'b00};
    req_off   = req_addr[1:0];
    range_err = (req_wa < START_ADDRESS) || (req_wa > LAST_WA);
    case (req_size)
      2'b00:   align_err = 1'b0;
      2'b01:   align_err = req_off[0];
      2'b10:   align_err = (req_off != 2'b00);
      default: align_err = 1'b1;
    endcase
  end

  function automatic logic [31:0] load_data(logic [31:0] word, logic [1:0] off,
                                            logic [1:0] size);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      2'b00:   load_data = {24'd0, sh[7:0]};
      2'b01:   load_data = {16'd0, sh[15:0]};
      default: load_data = sh;
    endcase
  endfunction

  // A half store only reaches here with an even offset, so off+1 stays in the word.
  function automatic logic [31:0] merge_word(logic [31:0] word, logic [1:0] off,
                                             logic [1:0] size, logic [31:0] wdata);
    logic [31:0] m;
    m = word;
    for (int i = 0; i < 4; i++) begin
      if (2'(i) == off)
        m[8*i +: 8] = wdata[7:0];
      else if (size == 2'b01 && 2'(i) == off + 2'd1)
        m[8*i +: 8] = wdata[15:8];
    end
    merge_word = m;
  endfunction

  // Next state, plus the next values of the registered outputs
  always_comb begin
    state_n     = state;
    own_d_n     = own_d;
    own_we_n    = own_we;
    own_size_n  = own_size;
    own_off_n   = own_off;
    own_wdata_n = own_wdata;
    word_n      = word_q;
    if_valid_n  = 1'b0;
    d_valid_n   = 1'b0;
    d_err_n     = 1'b0;
    mem_we_n    = 1'b0;
    if_rdata_n  = if_rdata_q;
    d_rdata_n   = d_rdata_q;
    mem_addr_n  = mem_addr_q;
    mem_din_n   = mem_din_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_d_n    = last_d;
`endif
    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
          own_d_n     = grant_d;
          own_we_n    = req_we;
          own_size_n  = req_size;
          own_off_n   = req_off;
          own_wdata_n = bus.d_wdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_d_n    = grant_d;
`endif
          if (range_err || align_err) begin
            // Rejected: respond on the next edge without touching memory
            state_n = RESP;
            if (grant_d) begin
              d_valid_n = 1'b1;
              d_err_n   = 1'b1;
              d_rdata_n = 32'd0;
            end else begin
              if_valid_n = 1'b1;
              if_rdata_n = 32'd0;
            end
          end else if (req_we && req_size == 2'b10) begin
            state_n    = WRITE;
            mem_addr_n = req_wa;
            mem_din_n  = bus.d_wdata;
            mem_we_n   = 1'b1;
          end else begin
            state_n    = READ;
            mem_addr_n = req_wa;
          end
        end
      end
      READ: begin
        word_n = bus.mem_data_out;
        if (own_d && own_we) begin
          state_n = MERGE;
        end else begin
          state_n = RESP;
          if (own_d) begin
            d_valid_n = 1'b1;
            d_rdata_n = load_data(bus.mem_data_out, own_off, own_size);
          end else begin
            if_valid_n = 1'b1;
            if_rdata_n = bus.mem_data_out;
          end
        end
      end
      MERGE: begin
        state_n   = WRITE;
        mem_din_n = merge_word(word_q, own_off, own_size, own_wdata);
        mem_we_n  = 1'b1;
      end
      WRITE: begin
        // Memory commits on the edge leaving this state
        state_n   = RESP;
        d_valid_n = 1'b1;
      end
      RESP: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      own_d      <= 1'b0;
      own_we     <= 1'b0;
      own_size   <= 2'b00;
      own_off    <= 2'b00;
      own_wdata  <= 32'd0;
      word_q     <= 32'd0;
      if_valid_q <= 1'b0;
      if_rdata_q <= 32'd0;
      d_valid_q  <= 1'b0;
      d_rdata_q  <= 32'd0;
      d_err_q    <= 1'b0;
      mem_addr_q <= START_ADDRESS;
      mem_din_q  <= 32'd0;
      mem_we_q   <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      own_d      <= own_d_n;
      own_we     <= own_we_n;
      own_size   <= own_size_n;
      own_off    <= own_off_n;
      own_wdata  <= own_wdata_n;
      word_q     <= word_n;
      if_valid_q <= if_valid_n;
      if_rdata_q <= if_rdata_n;
      d_valid_q  <= d_valid_n;
      d_rdata_q  <= d_rdata_n;
      d_err_q    <= d_err_n;
      mem_addr_q <= mem_addr_n;
      mem_din_q  <= mem_din_n;
      mem_we_q   <= mem_we_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d     <= last_d_n;
`endif
    end
  end

  assign bus.if_valid     = if_valid_q;
  assign bus.if_rdata     = if_rdata_q;
  assign bus.d_valid      = d_valid_q;
  assign bus.d_rdata      = d_rdata_q;
  assign bus.d_err        = d_err_q;
  assign bus.mem_address  = mem_addr_q;
  assign bus.mem_data_in  = mem_din_q;
  assign bus.mem_w_enable = mem_we_q;
  assign state_dbg        = state;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single memory port (`address`/`data_in`/`w_enable`/`data_out`, combinational read, posedge write) between the core's instruction-fetch and load/store units. Turns byte/half/word requests into aligned word accesses. Performs read-modify-write for sub-word stores and range/alignment checks against the memory window. Sits between the core pipeline and the `memory` instance; it is the only driver of the memory's inputs.

## Interface
- `START_ADDRESS`, 32'h01000000, first byte address of memory window
- `MEM_SIZE`, 1048576, window size in bytes
- `clk`  in  1  clock; all state changes on posedge
- `reset`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request; held with `if_addr` until `if_valid`
- `if_addr`  in  32  fetch byte address (word access)
- `if_valid`  out  1  one-cycle response pulse to fetch
- `if_rdata`  out  32  fetched word
- `d_req`  in  1  load/store request; held with operands until `d_valid`
- `d_we`  in  1  1 = store, 0 = load
- `d_size`  in  2  00 byte, 01 half, 10 word; 11 is an error
- `d_addr`  in  32  byte address
- `d_wdata`  in  32  store data, right-justified
- `d_valid`  out  1  one-cycle response pulse to load/store
- `d_rdata`  out  32  load data, right-justified, zero-filled above `d_size`
- `d_err`  out  1  valid with `d_valid`: access rejected, no memory side effect
- `mem_address`  out  32  to memory `address`, always word-aligned
- `mem_data_in`  out  32  to memory `data_in`
- `mem_w_enable`  out  1  to memory `w_enable`
- `mem_data_out`  in  32  from memory `data_out`

## Operation
- States: IDLE, READ, MERGE, WRITE, RESP. All outputs are registered.
- IDLE: sample requests at posedge. Winner is latched as owner, with its address, size and data.
- Fetch and load go to READ. Word store goes to WRITE. Byte/half store goes to READ, then MERGE.
- Checks are made at accept, against word base `wa = addr & ~3` and byte offset `off = addr[1:0]`.
- Out-of-range error: `wa < START_ADDRESS` or `wa > START_ADDRESS+MEM_SIZE-4`.
- Misalignment error: half with `off` odd, word or fetch with `off != 0`, or `d_size = 11`.
- Error goes directly to RESP with `d_err = 1`. No memory access occurs. A fetch error returns `if_rdata = 0`; fetch has no err port, and the core traps on its own PC check.
- READ: `mem_address = wa`, `mem_w_enable = 0`. At the posedge, `mem_data_out` is captured.
  - Load: `d_rdata = (word >> 8*off)`, masked to size.
  - Fetch: raw word.
- MERGE (sub-word store only): replace byte lane `off` (byte), or lanes `off` and `off+1` (half), of the captured word with `d_wdata` low bits.
- WRITE: `mem_w_enable = 1`, `mem_address = wa`, `mem_data_in` = merged or full word. The memory commits at the posedge ending WRITE.
- RESP: owner's `*_valid = 1` for exactly one cycle, then IDLE. The requester drops or changes `req` in the cycle after valid.
- A request arriving while busy waits; it is re-sampled in IDLE.
- Arbitration with both requesting in IDLE: load/store wins (fixed priority).

## Timing
- Reset values:
  - state IDLE
  - `mem_address = START_ADDRESS`, `mem_data_in = 0`, `mem_w_enable = 0`
  - `if_valid = d_valid = d_err = 0`, `if_rdata = d_rdata = 0`
- Acceptance edge E0. Valid is high in the cycle after:
  - fetch/load: E1 (2 cycles)
  - word store: E1 (2 cycles)
  - sub-word store: E3 (4 cycles)
  - error: E0 (1 cycle)
- `mem_w_enable` is high in exactly one cycle per store; never for loads, fetches or errors.
- Reset asserted mid-operation: immediate return to reset values.
  - If asserted during WRITE, `mem_w_enable` drops before the edge, so no partial write.
  - The requester must re-issue.
- Back-to-back: IDLE is occupied for at least one cycle between operations.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a tie in IDLE, grant the requester not granted on the previous accept.
  - Last-grant register resets to "fetch", so load/store wins the first tie.
  - A single requester is always granted.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, load/store over fetch; no last-grant register.

## Test plan
- Fetch at 0x01000000, memory word 0x00500093, `if_req` held -> `if_valid` pulse 2 cycles after accept, `if_rdata = 0x00500093`.
- Byte store 0xAB at 0x01000102 over old word 0x11223344 -> single `mem_w_enable` cycle writing 0x11AB3344 to 0x01000100; `d_valid` at accept+4; following byte load at 0x01000102 returns 0x000000AB.
- Half load at 0x01000101 -> `d_err = 1`, `d_valid` at accept+1, `mem_w_enable` never asserted. Word store at 0x00FFFFFC -> `d_err = 1`, memory unchanged.
- `if_req` and `d_req` held together for 4 operations:
  - macro undefined: order D,D,D,D.
  - macro defined: order D,F,D,F.
- Reset asserted in WRITE of word store 0xDEADBEEF to 0x01000010 -> outputs at reset values immediately; subsequent load of 0x01000010 returns original contents.
